// File: rtl/tick_window_sequencer_pkg.sv
// Shared definitions for the tick window sequencer: state codes (which are
// also the externally visible phase codes) and the phase width.
package tick_window_sequencer_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_SETTLE  = 2'd1,
    SEQ_MEASURE = 2'd2,
    SEQ_DONE    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tick_window_sequencer_tick_down_counter.sv
// tick_down_counter: WIDTH-bit loadable down-counter.
// Ports:
//   clk, rst   clock / async active-high reset (count -> 0)
//   en         global enable; nothing changes while low
//   clear      synchronous clear (highest priority)
//   load       synchronous load of load_val
//   dec        decrement by one
//   count      current value
//   last       count == 1
module tick_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             count <= '0;
    else if (en) begin
      if (clear)         count <= '0;
      else if (load)     count <= load_val;
      else if (dec)      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/tick_window_sequencer.sv
// tick_window_sequencer: counts prescaler ticks through a settle phase and a
// measurement phase, raising meas_win during measurement and pulsing done at
// the end of each sequence (aborted instead if the sequence is cut short).
// Ports:
//   clk, rst                 clock / async active-high reset
//   clk_ena                  global enable; all state holds while low
//   tick                     prescaler carry, counted only in SETTLE/MEASURE
//   start, abort             sequence control (abort wins)
//   settle_len, meas_len     phase lengths, captured at start
//   busy, meas_win, done     decoded from registered state
//   aborted                  registered one-enabled-cycle pulse
//   phase                    state code
//   remain                   ticks left in the current phase
module tick_window_sequencer
  import tick_window_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_ena,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   settle_len,
  input  logic [WIDTH-1:0]   meas_len,
  output logic               busy,
  output logic               meas_win,
  output logic               done,
  output logic               aborted,
  output logic [PHASE_W-1:0] phase,
  output logic [WIDTH-1:0]   remain
);

  seq_state_e       state;
  logic [WIDTH-1:0] meas_r;     // measurement length, already clamped to >= 1
  logic [WIDTH-1:0] meas_eff;
  logic [WIDTH-1:0] cnt_val;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_clear, cnt_load, cnt_dec, cnt_last;
  logic             abort_hit;

  // A zero measurement length still opens a one-tick window.
  assign meas_eff  = (meas_len == '0) ? WIDTH'(1) : meas_len;
  assign abort_hit = abort && (state != SEQ_IDLE);

  // Counter controls. The settle length goes straight into the counter at
  // start, so only the measurement length needs a held copy.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = meas_r;
    if (abort_hit) begin
      cnt_clear = 1'b1;
    end else begin
      case (state)
        SEQ_IDLE: if (start) begin
          cnt_load = 1'b1;
          cnt_val  = (settle_len != '0) ? settle_len : meas_eff;
        end
        SEQ_SETTLE: if (tick) begin
          if (cnt_last) cnt_load = 1'b1;
          else          cnt_dec  = 1'b1;
        end
        SEQ_MEASURE: if (tick) begin
          if (cnt_last) cnt_clear = 1'b1;
          else          cnt_dec   = 1'b1;
        end
        SEQ_DONE: cnt_clear = 1'b1;
        default:  cnt_clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEQ_IDLE;
      aborted <= 1'b0;
      meas_r  <= '0;
    end else if (clk_ena) begin
      aborted <= abort_hit;
      if (abort_hit) begin
        state <= SEQ_IDLE;
      end else begin
        case (state)
          SEQ_IDLE: if (start) begin
            meas_r <= meas_eff;
            state  <= (settle_len != '0) ? SEQ_SETTLE : SEQ_MEASURE;
          end
          SEQ_SETTLE:  if (tick && cnt_last) state <= SEQ_MEASURE;
          SEQ_MEASURE: if (tick && cnt_last) state <= SEQ_DONE;
          SEQ_DONE:    state <= SEQ_IDLE;
          default:     state <= SEQ_IDLE;
        endcase
      end
    end
  end

  tick_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_ena),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .last     (cnt_last)
  );

  assign busy     = (state != SEQ_IDLE);
  assign meas_win = (state == SEQ_MEASURE);
  assign done     = (state == SEQ_DONE);
  assign phase    = state;
  assign remain   = cnt_count;

endmodule

// File: tb/tb_tick_window_sequencer.sv
// Directed bench with a scoreboard: each stimulus step queues the expected
// post-edge phase/remain/aborted; a monitor pops and compares on negedges.
module tb_tick_window_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_ena = 1'b1;
  logic       tick = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] settle_len = '0, meas_len = '0;
  logic       busy, meas_win, done, aborted;
  logic [1:0] phase;
  logic [7:0] remain;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] rm;
    logic       ab;
  } exp_t;

  exp_t expq[$];

  tick_window_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clk_ena(clk_ena), .tick(tick), .start(start),
    .abort(abort), .settle_len(settle_len), .meas_len(meas_len),
    .busy(busy), .meas_win(meas_win), .done(done), .aborted(aborted),
    .phase(phase), .remain(remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive inputs for one edge and queue what the outputs must be after it.
  task automatic step(input logic t, input logic s, input logic a, input logic e,
                      input logic [1:0] ph, input logic [7:0] rm, input logic ab);
    tick = t; start = s; abort = a; clk_ena = e;
    @(posedge clk);
    expq.push_back('{ph, rm, ab});
    #1;
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("phase",    int'(phase),    int'(x.ph));
        chk("remain",   int'(remain),   int'(x.rm));
        chk("aborted",  int'(aborted),  int'(x.ab));
        chk("busy",     int'(busy),     int'(x.ph != 2'd0));
        chk("meas_win", int'(meas_win), int'(x.ph == 2'd2));
        chk("done",     int'(done),     int'(x.ph == 2'd3));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"},   int'(phase),   0);
    chk({tag, "_remain"},  int'(remain),  0);
    chk({tag, "_busy"},    int'(busy),    0);
    chk({tag, "_measwin"}, int'(meas_win),0);
    chk({tag, "_done"},    int'(done),    0);
    chk({tag, "_aborted"}, int'(aborted), 0);
  endtask

  initial begin
    #12 chk_all_zero("reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic: settle 2, meas 3, tick continuous
    settle_len = 8'd2; meas_len = 8'd3;
    step(1,1,0,1, 2'd1, 8'd2, 0);
    step(1,0,0,1, 2'd1, 8'd1, 0);
    step(1,0,0,1, 2'd2, 8'd3, 0);
    step(1,0,0,1, 2'd2, 8'd2, 0);
    step(1,0,0,1, 2'd2, 8'd1, 0);
    step(1,0,0,1, 2'd3, 8'd0, 0);
    step(1,0,0,1, 2'd0, 8'd0, 0);
    step(1,0,0,1, 2'd0, 8'd0, 0);

    // Zero lengths, tick every 4th cycle
    settle_len = 8'd0; meas_len = 8'd0;
    step(0,1,0,1, 2'd2, 8'd1, 0);
    step(0,0,0,1, 2'd2, 8'd1, 0);
    step(0,0,0,1, 2'd2, 8'd1, 0);
    step(1,0,0,1, 2'd3, 8'd0, 0);
    step(0,0,0,1, 2'd0, 8'd0, 0);

    // Abort in MEASURE at remain=2 together with a tick; then abort in IDLE
    settle_len = 8'd1; meas_len = 8'd3;
    step(0,1,0,1, 2'd1, 8'd1, 0);
    step(1,0,0,1, 2'd2, 8'd3, 0);
    step(1,0,0,1, 2'd2, 8'd2, 0);
    step(1,0,1,1, 2'd0, 8'd0, 1);
    step(0,0,1,1, 2'd0, 8'd0, 0);
    step(1,0,0,1, 2'd0, 8'd0, 0);

    // clk_ena gating: lost tick in MEASURE, done stretched over 5 disabled cycles
    settle_len = 8'd0; meas_len = 8'd2;
    step(0,1,0,1, 2'd2, 8'd2, 0);
    step(1,0,0,0, 2'd2, 8'd2, 0);
    step(1,0,0,1, 2'd2, 8'd1, 0);
    step(1,0,0,1, 2'd3, 8'd0, 0);
    for (int i = 0; i < 5; i++) step(1,0,0,0, 2'd3, 8'd0, 0);
    step(0,0,0,1, 2'd0, 8'd0, 0);

    // Start+tick in IDLE, starts while busy / in DONE ignored
    settle_len = 8'd3; meas_len = 8'd2;
    step(1,1,0,1, 2'd1, 8'd3, 0);
    settle_len = 8'd9; meas_len = 8'd9;
    step(1,1,0,1, 2'd1, 8'd2, 0);
    step(1,0,0,1, 2'd1, 8'd1, 0);
    step(1,0,0,1, 2'd2, 8'd2, 0);
    step(1,0,0,1, 2'd2, 8'd1, 0);
    step(1,1,0,1, 2'd3, 8'd0, 0);
    step(0,1,0,1, 2'd0, 8'd0, 0);
    step(0,0,0,1, 2'd0, 8'd0, 0);

    // Reset mid-SETTLE, asserted between edges
    settle_len = 8'd5; meas_len = 8'd1;
    step(0,1,0,1, 2'd1, 8'd5, 0);
    step(1,0,0,1, 2'd1, 8'd4, 0);
    #6 rst = 1'b1;
    #1 chk_all_zero("midrst");
    tick = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step(1,0,0,1, 2'd0, 8'd0, 0);
    step(1,0,1,1, 2'd0, 8'd0, 0);
    step(0,0,0,1, 2'd0, 8'd0, 0);

    repeat (2) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
